// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer for a shared combinational ALU.
// Latches one requester's operands, captures the result and acks that requester.
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OPRN_WIDTH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] op1_0,
  input  logic [DATA_WIDTH-1:0] op2_0,
  input  logic [DATA_WIDTH-1:0] op1_1,
  input  logic [DATA_WIDTH-1:0] op2_1,
  input  logic [OPRN_WIDTH-1:0] oprn_0,
  input  logic [OPRN_WIDTH-1:0] oprn_1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  err,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [OPRN_WIDTH-1:0] alu_oprn,
  input  logic [DATA_WIDTH-1:0] alu_result
);

  localparam logic [OPRN_WIDTH-1:0] OPRN_MIN = OPRN_WIDTH'(1);
  localparam logic [OPRN_WIDTH-1:0] OPRN_MAX = OPRN_WIDTH'(9);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_pri;
  logic                  r_gnt;
  logic                  r_ack0;
  logic                  r_ack1;
  logic                  r_err;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0] r_alu_op1;
  logic [DATA_WIDTH-1:0] r_alu_op2;
  logic [OPRN_WIDTH-1:0] r_alu_oprn;

  logic w_any_req;
  logic w_gnt;
  logic w_oprn_ok;

  // On a tie the pointer decides; a lone requester always wins.
  assign w_any_req = req0 | req1;
  assign w_gnt     = (req0 & req1) ? r_pri : req1;
  assign w_oprn_ok = (r_alu_oprn >= OPRN_MIN) && (r_alu_oprn <= OPRN_MAX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_pri      <= 1'b0;
      r_gnt      <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_result   <= '0;
      r_alu_op1  <= '0;
      r_alu_op2  <= '0;
      r_alu_oprn <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_gnt      <= w_gnt;
            r_pri      <= ~w_gnt;
            r_alu_op1  <= w_gnt ? op1_1  : op1_0;
            r_alu_op2  <= w_gnt ? op2_1  : op2_0;
            r_alu_oprn <= w_gnt ? oprn_1 : oprn_0;
            r_busy     <= 1'b1;
            r_state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Unsupported codes never expose the ALU's undefined output.
          r_result <= w_oprn_ok ? alu_result : '0;
          r_err    <= ~w_oprn_ok;
          r_ack0   <= ~r_gnt;
          r_ack1   <= r_gnt;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign result   = r_result;
  assign err      = r_err;
  assign busy     = r_busy;
  assign alu_op1  = r_alu_op1;
  assign alu_op2  = r_alu_op2;
  assign alu_oprn = r_alu_oprn;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level reference model,
// per-cycle output compare, directed literal checks and randomized traffic.
module tb_alu_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] op1_0 = '0, op2_0 = '0, op1_1 = '0, op2_1 = '0;
  logic [5:0]  oprn_0 = '0, oprn_1 = '0;
  logic        ack0, ack1, err, busy;
  logic [31:0] result, alu_op1, alu_op2, alu_result;
  logic [5:0]  alu_oprn;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  alu_arbiter dut (
    .CLK(CLK), .RST(RST), .req0(req0), .req1(req1),
    .op1_0(op1_0), .op2_0(op2_0), .op1_1(op1_1), .op2_1(op2_1),
    .oprn_0(oprn_0), .oprn_1(oprn_1),
    .ack0(ack0), .ack1(ack1), .result(result), .err(err), .busy(busy),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_oprn(alu_oprn),
    .alu_result(alu_result)
  );

  // Behavioural ALU; codes outside 1..9 give garbage that must never surface.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [5:0] op);
    case (op)
      6'd1:    return a + b;
      6'd2:    return a - b;
      6'd3:    return a * b;
      6'd4:    return a << b;
      6'd5:    return a >> b;
      6'd6:    return a & b;
      6'd7:    return a | b;
      6'd8:    return a ^ b;
      6'd9:    return {31'b0, (a < b)};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op1, alu_op2, alu_oprn);

  // Transaction model: an accepted request occupies 3 cycles, ack on the last.
  int          m_left = 0;
  logic        m_pri = 1'b0, m_g = 1'b0;
  logic [1:0]  m_ack = 2'b00;
  logic        m_err = 1'b0;
  logic [31:0] m_res = '0, m_op1 = '0, m_op2 = '0;
  logic [5:0]  m_oprn = '0;

  function automatic logic pick(input logic r0, input logic r1, input logic pri);
    return (r0 && r1) ? pri : r1;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_left <= 0; m_pri <= 1'b0; m_g <= 1'b0; m_ack <= 2'b00;
      m_err <= 1'b0; m_res <= '0; m_op1 <= '0; m_op2 <= '0; m_oprn <= '0;
    end else begin
      m_ack <= 2'b00;
      if (m_left == 0) begin
        if (req0 || req1) begin
          m_g    <= pick(req0, req1, m_pri);
          m_pri  <= ~pick(req0, req1, m_pri);
          m_op1  <= pick(req0, req1, m_pri) ? op1_1  : op1_0;
          m_op2  <= pick(req0, req1, m_pri) ? op2_1  : op2_0;
          m_oprn <= pick(req0, req1, m_pri) ? oprn_1 : oprn_0;
          m_left <= 2;
        end
      end else if (m_left == 2) begin
        if (m_oprn >= 6'd1 && m_oprn <= 6'd9) begin
          m_res <= alu_fn(m_op1, m_op2, m_oprn);
          m_err <= 1'b0;
        end else begin
          m_res <= '0;
          m_err <= 1'b1;
        end
        m_ack[m_g] <= 1'b1;
        m_left <= 1;
      end else begin
        m_left <= 0;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      tests++;
      if ({ack1, ack0, busy, err, result, alu_op1, alu_op2, alu_oprn} !==
          {m_ack, (m_left != 0), m_err, m_res, m_op1, m_op2, m_oprn}) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got ack=%b%b busy=%b err=%b res=%h a=%h b=%h op=%h want ack=%b busy=%b err=%b res=%h a=%h b=%h op=%h",
                 $time, ack1, ack0, busy, err, result, alu_op1, alu_op2, alu_oprn,
                 m_ack, (m_left != 0), m_err, m_res, m_op1, m_op2, m_oprn);
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_ops(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] op);
    if (r == 0) begin op1_0 = a; op2_0 = b; oprn_0 = op; end
    else        begin op1_1 = a; op2_1 = b; oprn_1 = op; end
  endtask

  // One request from IDLE; checks latency, ack identity and the literal result.
  task automatic run_op(input string nm, input int r, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] op,
                        input logic [31:0] exp_res, input logic exp_err);
    int n;
    bit other_ack;
    @(negedge CLK);
    set_ops(r, a, b, op);
    if (r == 0) req0 = 1'b1; else req1 = 1'b1;
    n = 0;
    other_ack = 1'b0;
    do begin
      @(negedge CLK);
      n++;
      if ((r == 0) ? ack1 : ack0) other_ack = 1'b1;
    end while (!((r == 0) ? ack0 : ack1) && n < 10);
    check({nm, "_latency"}, 64'(n), 64'd2);
    check({nm, "_other_ack"}, 64'(other_ack), 64'd0);
    check({nm, "_result"}, {31'b0, err, result}, {31'b0, exp_err, exp_res});
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    bit [1:0] rq;
    int n;
    repeat (2) @(negedge CLK);
    chk_en = 1'b1;
    check("reset_outputs", {ack1, ack0, busy, err, result, alu_op1[31:0]}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Tie fairness from reset: 0,1,0,1 alternation with literal results.
    set_ops(0, 32'd10, 32'd3, 6'h02);
    set_ops(1, 32'd20, 32'd4, 6'h02);
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge CLK); n++; end while (!(ack0 || ack1) && n < 10);
      check($sformatf("tie_ack_%0d", k), {62'b0, ack1, ack0},
            (k % 2 == 0) ? 64'b01 : 64'b10);
      check($sformatf("tie_res_%0d", k), 64'(result), (k % 2 == 0) ? 64'd7 : 64'd16);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge CLK);

    run_op("add_single", 0, 32'd5, 32'd7, 6'h01, 32'd12, 1'b0);
    run_op("inv_op00", 1, 32'd5, 32'd7, 6'h00, 32'd0, 1'b1);
    run_op("err_clear", 1, 32'd9, 32'd4, 6'h02, 32'd5, 1'b0);
    run_op("inv_op0a", 1, 32'd5, 32'd7, 6'h0A, 32'd0, 1'b1);
    run_op("add_wrap", 0, 32'hFFFF_FFFF, 32'd1, 6'h01, 32'd0, 1'b0);
    run_op("mul_trunc", 0, 32'h0001_0000, 32'h0001_0000, 6'h03, 32'd0, 1'b0);
    run_op("slt_unsigned", 1, 32'hFFFF_FFFF, 32'd1, 6'h09, 32'd0, 1'b0);
    run_op("shl_big", 0, 32'd1, 32'd40, 6'h04, 32'd0, 1'b0);

    // Operand change after the grant edge must not affect the result.
    @(negedge CLK);
    set_ops(0, 32'd100, 32'd1, 6'h01);
    req0 = 1'b1;
    @(negedge CLK);
    op1_0 = 32'd500;
    req0 = 1'b0;
    @(negedge CLK);
    check("op_change_ack", {63'b0, ack0}, 64'd1);
    check("op_change_res", 64'(result), 64'd101);

    // Reset during EXEC: immediate clear, no ack afterwards.
    @(negedge CLK);
    set_ops(0, 32'd3, 32'd4, 6'h01);
    req0 = 1'b1;
    @(negedge CLK);
    req0 = 1'b0;
    RST = 1'b1;
    #1;
    check("rst_mid_outputs", {ack1, ack0, busy, err, result, alu_op1[31:0]}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    n = 0;
    repeat (4) begin @(negedge CLK); if (ack0 || ack1) n++; end
    check("rst_no_ack", 64'(n), 64'd0);
    run_op("after_reset", 0, 32'd8, 32'd2, 6'h05, 32'd2, 1'b0);

    // Randomized traffic; requests held until ack, sometimes kept high afterwards.
    rq = 2'b00;
    repeat (600) begin
      @(negedge CLK);
      for (int r = 0; r < 2; r++) begin
        if (rq[r]) begin
          if (((r == 0) ? ack0 : ack1) && ($urandom % 2 == 0)) rq[r] = 1'b0;
        end else begin
          set_ops(r, ($urandom % 4 == 0) ? 32'($urandom % 8) : 32'($urandom),
                  ($urandom % 3 == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom),
                  6'($urandom_range(0, 11)));
          if ($urandom % 3 == 0) rq[r] = 1'b1;
        end
      end
      req0 = rq[0];
      req1 = rq[1];
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (5) @(negedge CLK);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
